data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (single-beat accesses) and a DMA/loader port (multi-beat bursts with address auto-increment).
- Sits between the core/DMA logic and the data memory. It drives the memory's address, read-enable, write-enable and write-data inputs, and routes the memory's read data back to the winning requester.
- Core has priority. A streak counter guarantees that a pending DMA request is served after a bounded number of core beats.

Parameters:
- MAX_STREAK, 4: maximum consecutive core beats granted while d_req is pending; must be >= 1.
- LEN_W, 4: width of the DMA burst-length field; maximum burst is 2^LEN_W - 1 beats.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- c_req  input  1  core access request, held until c_gnt.
- c_we  input  1  core access type: 1 = write, 0 = read.
- c_addr  input  8  core byte address.
- c_wdata  input  8  core write data.
- c_gnt  output  1  core beat performed this cycle (combinational).
- c_rdata  output  8  read data; valid only when c_gnt=1 and c_we=0.
- d_req  input  1  DMA burst request; d_we, d_addr and d_len are held stable until d_gnt.
- d_we  input  1  burst type: 1 = write, 0 = read.
- d_addr  input  8  burst start address.
- d_len  input  LEN_W  burst beat count; 0 is treated as 1.
- d_gnt  output  1  one-cycle pulse when the burst is accepted (combinational).
- d_wdata  input  8  write data, sampled in each d_beat cycle.
- d_beat  output  1  one DMA beat performed this cycle.
- d_rdata  output  8  read data; valid when d_beat=1 on a read burst.
- d_done  output  1  high together with d_beat on the last beat.
- mem_addr  output  8  address to the data memory.
- mem_read  output  1  read enable to the data memory.
- mem_write  output  1  write enable to the data memory.
- mem_wdata  output  8  write data to the data memory.
- mem_rdata  input  8  read data from the data memory (combinational read, tristated when not reading).

Behaviour:
- States: IDLE and BURST.
- Registers: state, burst_addr[7:0], burst_cnt[LEN_W-1:0], burst_we, streak (counts 0..MAX_STREAK).
- Reset (reset=0, asynchronous): state=IDLE, all registers 0. All outputs then evaluate to 0: c_gnt, d_gnt, d_beat, d_done, mem_read, mem_write, mem_addr, mem_wdata, c_rdata, d_rdata.
- At most one memory operation per cycle.
  - Read latency: 0 cycles (memory read is combinational).
  - Write takes effect at the posedge ending the grant or beat cycle.
- IDLE:
  - If c_req and (!d_req or streak < MAX_STREAK): perform a core beat. c_gnt=1, mem_addr=c_addr, mem_read=!c_we, mem_write=c_we, mem_wdata=c_wdata, c_rdata=mem_rdata. streak increments if d_req=1, otherwise clears to 0.
  - Else if d_req: d_gnt=1, no memory operation this cycle.
    - Latch burst_addr=d_addr, burst_we=d_we, burst_cnt=(d_len==0 ? 1 : d_len).
    - Clear streak, go to BURST.
  - Else: idle cycle, streak=0.
- BURST:
  - Each cycle: d_beat=1, mem_addr=burst_addr, mem_read=!burst_we, mem_write=burst_we, mem_wdata=d_wdata, d_rdata=mem_rdata.
  - burst_addr increments by 1 per beat and wraps 8'hFF -> 8'h00.
  - burst_cnt decrements. On the beat where burst_cnt==1: d_done=1, go to IDLE.
  - c_gnt=0 throughout; the core stalls. d_req is ignored.
- Idle-cycle outputs: whenever no beat occurs, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, c_rdata=0, d_rdata=0.
- Back-to-back: the cycle after d_done re-enters IDLE arbitration. A waiting core wins if streak < MAX_STREAK (streak is 0 after a burst).
- Reset mid-burst: the burst is aborted with no d_done, and the memory sees no further writes.
- Simultaneous c_req and d_req with streak == MAX_STREAK: the DMA wins, and the core request remains pending.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, BURST}
  - constant ADDR_W=8, DATA_W=8
- Sub-module mem_arb_burst_ctr: burst_addr/burst_cnt load, decrement and wrap, with a last_beat flag.
- The FSM, streak counter and output muxing stay in the top module.

Test Plan:
- Reset release, then core write 8'h2A to 8'h10, then core read 8'h10 -> c_gnt=1 on both cycles; c_rdata=8'h2A; d_* outputs stay 0.
- DMA write burst: d_addr=8'hFE, d_len=3, d_wdata 1,2,3 -> d_gnt pulse, then 3 d_beat cycles at addresses FE, FF, 00; d_done on the third. DMA read of the same range returns 1, 2, 3.
- d_len=0 -> exactly one beat, with d_done in the same cycle as d_beat.
- c_req held continuously with d_req=1, MAX_STREAK=4 -> exactly 4 c_gnt, then d_gnt, then the burst, then c_gnt resumes.
- c_req asserted during a 5-beat burst -> c_gnt=0 for all 5 beats; c_gnt=1 the cycle after d_done.
- reset driven low at beat 2 of a 4-beat write burst -> all outputs 0 immediately, no d_done; addresses for beats 3-4 are unmodified on readback.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mem_arb_burst_ctr.sv
// DMA burst address/length tracker: loads on grant, steps once per beat and
// flags the final beat of the burst.
module mem_arb_burst_ctr
   import mem_arb_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   output logic [ADDR_W-1:0] burst_addr,
   output logic              last_beat
);

   logic [LEN_W-1:0] burst_cnt;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         burst_addr <= '0;
         burst_cnt  <= '0;
      end else if (load) begin
         burst_addr <= load_addr;
         // A zero length still moves one beat.
         burst_cnt  <= (load_len == '0) ? LEN_W'(1) : load_len;
      end else if (step) begin
         burst_addr <= burst_addr + ADDR_W'(1);
         burst_cnt  <= burst_cnt - LEN_W'(1);
      end
   end

   assign last_beat = (burst_cnt == LEN_W'(1));

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: core single beats with priority, DMA
// bursts served after at most MAX_STREAK core beats while DMA is waiting.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4,
   parameter int LEN_W      = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LEN_W-1:0]  d_len,
   output logic              d_gnt,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_beat,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int STREAK_W = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   arb_state_t           state;
   logic [STREAK_W-1:0]  streak;
   logic                 burst_we;
   logic [ADDR_W-1:0]    burst_addr;
   logic                 last_beat;
   logic                 in_burst;
   logic                 core_win;
   logic                 dma_win;

   // Gating with reset keeps every output at zero while reset is held,
   // even if requesters keep asserting their inputs.
   assign in_burst = reset && (state == BURST);
   assign core_win = reset && (state == IDLE) && c_req &&
                     (!d_req || (streak < STREAK_MAX));
   assign dma_win  = reset && (state == IDLE) && d_req && !core_win;

   mem_arb_burst_ctr #(
      .LEN_W (LEN_W)
   ) u_burst_ctr (
      .CLK        (CLK),
      .reset      (reset),
      .load       (dma_win),
      .step       (in_burst),
      .load_addr  (d_addr),
      .load_len   (d_len),
      .burst_addr (burst_addr),
      .last_beat  (last_beat)
   );

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         streak   <= '0;
         burst_we <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (core_win) begin
                  // Only count core beats that actually made the DMA wait.
                  streak <= d_req ? streak + STREAK_W'(1) : '0;
               end else if (d_req) begin
                  burst_we <= d_we;
                  streak   <= '0;
                  state    <= BURST;
               end else begin
                  streak <= '0;
               end
            end
            BURST: begin
               if (last_beat) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      c_gnt     = 1'b0;
      c_rdata   = '0;
      d_gnt     = dma_win;
      d_beat    = 1'b0;
      d_rdata   = '0;
      d_done    = 1'b0;
      mem_addr  = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = '0;
      if (in_burst) begin
         d_beat    = 1'b1;
         d_done    = last_beat;
         mem_addr  = burst_addr;
         mem_read  = !burst_we;
         mem_write = burst_we;
         mem_wdata = d_wdata;
         d_rdata   = mem_rdata;
      end else if (core_win) begin
         c_gnt     = 1'b1;
         mem_addr  = c_addr;
         mem_read  = !c_we;
         mem_write = c_we;
         mem_wdata = c_wdata;
         c_rdata   = mem_rdata;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table plus randomized traffic
// checked against a transaction-level model with its own memory image.
module tb_data_mem_arbiter;

   localparam int MAX_STREAK = 4;
   localparam int LEN_W      = 4;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       c_req = 1'b0, c_we = 1'b0;
   logic [7:0] c_addr = '0, c_wdata = '0;
   logic       c_gnt;
   logic [7:0] c_rdata;
   logic       d_req = 1'b0, d_we = 1'b0;
   logic [7:0] d_addr = '0;
   logic [3:0] d_len = '0;
   logic       d_gnt;
   logic [7:0] d_wdata = '0;
   logic       d_beat, d_done;
   logic [7:0] d_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_read, mem_write;

   always #5 CLK = ~CLK;

   data_mem_arbiter #(
      .MAX_STREAK (MAX_STREAK),
      .LEN_W      (LEN_W)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_gnt     (c_gnt),
      .c_rdata   (c_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_len     (d_len),
      .d_gnt     (d_gnt),
      .d_wdata   (d_wdata),
      .d_beat    (d_beat),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Physical memory attached to the DUT; reads as 0 when not enabled.
   logic [7:0] mem_q [256];
   always @(posedge CLK) begin
      if (mem_write) mem_q[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem_read ? mem_q[mem_addr] : 8'h00;

   typedef struct packed {
      logic       c_gnt, d_gnt, d_beat, d_done, mem_read, mem_write;
      logic [7:0] mem_addr, mem_wdata, c_rdata, d_rdata;
   } outs_t;

   typedef struct {
      logic       rst, c_req, c_we;
      logic [7:0] c_addr, c_wdata;
      logic       d_req, d_we;
      logic [7:0] d_addr;
      logic [3:0] d_len;
      logic [7:0] d_wdata;
      logic [3:0] e_flags;   // {c_gnt, d_gnt, d_beat, d_done}
      logic [7:0] e_addr, e_crd, e_drd;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // Transaction-level model: pending burst as (next address, beats left).
   bit         m_in_burst;
   bit         m_we;
   int         m_left, m_addr, m_streak;
   logic [7:0] ref_mem [256];

   function automatic outs_t predict();
      outs_t o = '0;
      if (!reset) return o;
      if (m_in_burst) begin
         o.d_beat    = 1'b1;
         o.d_done    = (m_left == 1);
         o.mem_addr  = 8'(m_addr);
         o.mem_read  = !m_we;
         o.mem_write = m_we;
         o.mem_wdata = d_wdata;
         o.d_rdata   = m_we ? 8'h00 : ref_mem[8'(m_addr)];
      end else if (c_req && (!d_req || m_streak < MAX_STREAK)) begin
         o.c_gnt     = 1'b1;
         o.mem_addr  = c_addr;
         o.mem_read  = !c_we;
         o.mem_write = c_we;
         o.mem_wdata = c_wdata;
         o.c_rdata   = c_we ? 8'h00 : ref_mem[c_addr];
      end else if (d_req) begin
         o.d_gnt = 1'b1;
      end
      return o;
   endfunction

   task automatic model_update();
      if (!reset) begin
         m_in_burst = 0; m_we = 0; m_left = 0; m_addr = 0; m_streak = 0;
      end else if (m_in_burst) begin
         if (m_we) ref_mem[8'(m_addr)] = d_wdata;
         m_addr = (m_addr + 1) % 256;
         m_left = m_left - 1;
         if (m_left == 0) m_in_burst = 0;
      end else if (c_req && (!d_req || m_streak < MAX_STREAK)) begin
         if (c_we) ref_mem[c_addr] = c_wdata;
         m_streak = d_req ? m_streak + 1 : 0;
      end else if (d_req) begin
         m_in_burst = 1;
         m_we       = d_we;
         m_addr     = int'(d_addr);
         m_left     = (d_len == 0) ? 1 : int'(d_len);
         m_streak   = 0;
      end else begin
         m_streak = 0;
      end
   endtask

   // Inputs are set 1 time unit after posedge; outputs sampled at negedge.
   task automatic run_cycle(input string tag, output outs_t p, output outs_t a);
      p = predict();
      @(negedge CLK);
      a = {c_gnt, d_gnt, d_beat, d_done, mem_read, mem_write,
           mem_addr, mem_wdata, c_rdata, d_rdata};
      n_cmp++;
      if (a !== p) begin
         n_fail++;
         $display("FAIL %s model: got %h expected %h", tag, a, p);
      end
      @(posedge CLK);
      model_update();
      #1;
   endtask

   function automatic vec_t mk(int rst, int cr, int cw, int ca, int cwd,
                               int dr, int dw, int da, int dl, int dwd,
                               int fl, int ea, int ecrd, int edrd);
      vec_t v;
      v.rst = 1'(rst);  v.c_req = 1'(cr); v.c_we = 1'(cw);
      v.c_addr = 8'(ca); v.c_wdata = 8'(cwd);
      v.d_req = 1'(dr); v.d_we = 1'(dw); v.d_addr = 8'(da);
      v.d_len = 4'(dl); v.d_wdata = 8'(dwd);
      v.e_flags = 4'(fl); v.e_addr = 8'(ea); v.e_crd = 8'(ecrd); v.e_drd = 8'(edrd);
      return v;
   endfunction

   vec_t  vecs[$];
   outs_t p, a;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_q[i]   = 8'h00;
         ref_mem[i] = 8'h00;
      end
      m_in_burst = 0; m_we = 0; m_left = 0; m_addr = 0; m_streak = 0;

      // Core write/read
      vecs.push_back(mk(1, 1,1,'h10,'h2A, 0,0,0,0,0,    'b1000,'h10,0,0));
      vecs.push_back(mk(1, 1,0,'h10,0,    0,0,0,0,0,    'b1000,'h10,'h2A,0));
      // DMA write burst wrapping FE->FF->00, then read back
      vecs.push_back(mk(1, 0,0,0,0, 1,1,'hFE,3,0,       'b0100,0,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,1,          'b0010,'hFE,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,2,          'b0010,'hFF,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,3,          'b0011,'h00,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 1,0,'hFE,3,0,       'b0100,0,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0010,'hFE,0,1));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0010,'hFF,0,2));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0011,'h00,0,3));
      // d_len = 0 gives one beat
      vecs.push_back(mk(1, 0,0,0,0, 1,0,'h10,0,0,       'b0100,0,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0011,'h10,0,'h2A));
      // Streak limit: 4 core beats, then DMA wins
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1, 1,0,'h10,0, 1,1,'h20,1,'h55, 'b1000,'h10,'h2A,0));
      vecs.push_back(mk(1, 1,0,'h10,0, 1,1,'h20,1,'h55, 'b0100,0,0,0));
      vecs.push_back(mk(1, 1,0,'h10,0, 1,1,'h20,1,'h55, 'b0011,'h20,0,0));
      vecs.push_back(mk(1, 1,0,'h10,0, 0,0,0,0,0,       'b1000,'h10,'h2A,0));
      // Core stalled through a 5-beat burst
      vecs.push_back(mk(1, 0,0,0,0, 1,1,'h30,5,0,       'b0100,0,0,0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 1,0,'h20,0, 0,0,0,0,'hA0+i,
                           (i == 4) ? 'b0011 : 'b0010, 'h30+i,0,0));
      vecs.push_back(mk(1, 1,0,'h20,0, 0,0,0,0,0,       'b1000,'h20,'h55,0));
      // Reset at beat 2 of a 4-beat write burst; core write held during reset
      vecs.push_back(mk(1, 0,0,0,0, 1,1,'h40,4,0,       'b0100,0,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,'h11,       'b0010,'h40,0,0));
      vecs.push_back(mk(0, 1,1,'h41,'hEE, 0,0,0,0,'h12, 'b0000,0,0,0));
      vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,'h13,       'b0000,0,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 1,0,'h40,4,0,       'b0100,0,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0010,'h40,0,'h11));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0010,'h41,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0010,'h42,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0011,'h43,0,0));
      vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0,          'b0000,0,0,0));

      // Reset state with both requesters asserting
      @(posedge CLK); #1;
      reset = 1'b0; c_req = 1'b1; d_req = 1'b1; c_we = 1'b1; c_addr = 8'h05;
      for (int i = 0; i < 2; i++) begin
         run_cycle("reset", p, a);
         n_cmp++;
         if (a !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h expected 0", a);
         end
         $display("reset cycle %0d outputs %h", i, a);
      end

      foreach (vecs[i]) begin
         reset   = vecs[i].rst;
         c_req   = vecs[i].c_req;  c_we    = vecs[i].c_we;
         c_addr  = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
         d_req   = vecs[i].d_req;  d_we    = vecs[i].d_we;
         d_addr  = vecs[i].d_addr; d_len   = vecs[i].d_len;
         d_wdata = vecs[i].d_wdata;
         run_cycle($sformatf("vec%0d", i), p, a);
         n_cmp++;
         if ({a.c_gnt, a.d_gnt, a.d_beat, a.d_done, a.mem_addr, a.c_rdata, a.d_rdata} !==
             {vecs[i].e_flags, vecs[i].e_addr, vecs[i].e_crd, vecs[i].e_drd}) begin
            n_fail++;
            $display("FAIL vec%0d: got flags=%b addr=%h crd=%h drd=%h expected flags=%b addr=%h crd=%h drd=%h",
                     i, {a.c_gnt, a.d_gnt, a.d_beat, a.d_done}, a.mem_addr, a.c_rdata, a.d_rdata,
                     vecs[i].e_flags, vecs[i].e_addr, vecs[i].e_crd, vecs[i].e_drd);
         end
         $display("vec%0d: flags=%b addr=%h crd=%h drd=%h", i,
                  {a.c_gnt, a.d_gnt, a.d_beat, a.d_done}, a.mem_addr, a.c_rdata, a.d_rdata);
      end

      // Randomized traffic obeying the hold-until-grant protocol
      c_req = 1'b0; d_req = 1'b0; reset = 1'b1;
      for (int n = 0; n < 800; n++) begin
         run_cycle($sformatf("rand%0d", n), p, a);
         if (p.c_gnt)
            $display("rand%0d: core %s addr=%h data=%h", n, c_we ? "wr" : "rd",
                     c_addr, c_we ? c_wdata : a.c_rdata);
         if (p.d_gnt)
            $display("rand%0d: dma %s addr=%h len=%0d", n, d_we ? "wr" : "rd",
                     d_addr, d_len);
         if (!c_req || p.c_gnt || !reset) begin
            c_req   = ($urandom % 4) != 0;
            c_we    = 1'($urandom);
            c_addr  = 8'($urandom_range(0, 15));
            c_wdata = 8'($urandom);
         end
         if (!d_req || p.d_gnt || !reset) begin
            d_req  = ($urandom % 5) == 0;
            d_we   = 1'($urandom);
            d_addr = 8'($urandom_range(0, 15)) - 8'd4;
            d_len  = 4'($urandom);
         end
         d_wdata = 8'($urandom);
         reset   = ($urandom % 150) != 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
